// File: rtl/syn_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty
// thresholds, overflow/underflow pulses and selectable standard/FWFT read.
// DEPTH may be any integer >= 2; pointers wrap explicitly at DEPTH-1.
module syn_fifo_flags #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2,
   parameter int FWFT     = 0,
   localparam int PW      = $clog2(DEPTH),
   localparam int CW      = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             winc,
   input  logic [WIDTH-1:0] wdata,
   input  logic             rinc,
   output logic [WIDTH-1:0] rdata,
   output logic             wfull,
   output logic             rempty,
   output logic             almost_full,
   output logic             almost_empty,
   output logic [CW-1:0]    count,
   output logic             overflow,
   output logic             underflow
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wptr;
   logic [PW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;
   logic             r_ovf;
   logic             r_unf;

   logic             w_full;
   logic             w_empty;
   logic             w_wacc;
   logic             w_racc;
   logic [PW-1:0]    w_wptr_nxt;
   logic [PW-1:0]    w_rptr_nxt;

   // Flags decode from the count register only, so no input reaches them.
   assign w_full       = (r_count == CW'(DEPTH));
   assign w_empty      = (r_count == '0);
   assign wfull        = w_full;
   assign rempty       = w_empty;
   assign almost_full  = (r_count >= CW'(AF_LEVEL));
   assign almost_empty = (r_count <= CW'(AE_LEVEL));
   assign count        = r_count;
   assign overflow     = r_ovf;
   assign underflow    = r_unf;

   // Acceptance is judged on the pre-edge flags, so a full FIFO rejects a
   // write even when a read frees a slot on the same edge (and vice versa).
   assign w_wacc = winc && !w_full;
   assign w_racc = rinc && !w_empty;

   // Non-power-of-two depth: wrap explicitly rather than relying on rollover.
   assign w_wptr_nxt = (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + PW'(1);
   assign w_rptr_nxt = (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + PW'(1);

   // Storage array; deliberately not reset.
   always_ff @(posedge clk) begin
      if (w_wacc) r_mem[r_wptr] <= wdata;
   end

   // Pointers, occupancy and the error pulses.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else begin
         if (w_wacc) r_wptr <= w_wptr_nxt;
         if (w_racc) r_rptr <= w_rptr_nxt;
         case ({w_wacc, w_racc})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         r_ovf <= winc && w_full;
         r_unf <= rinc && w_empty;
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         // Head word is shown directly; valid whenever rempty is low.
         assign rdata = r_mem[r_rptr];
      end else begin : g_std
         logic [WIDTH-1:0] r_rdata;
         // Registered read: load the head word on an accepted read, else hold.
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn)       r_rdata <= '0;
            else if (w_racc) r_rdata <= r_mem[r_rptr];
         end
         assign rdata = r_rdata;
      end
   endgenerate

endmodule

// File: tb/tb_syn_fifo_flags.sv
// Scoreboard bench: dut0 is DEPTH=16 standard mode, dut1 is DEPTH=5 FWFT.
// The driver runs a queue-based reference model and pushes the expected
// post-edge state; a separate monitor pops and compares after each edge.
module tb_syn_fifo_flags;

   typedef struct {
      int         id;
      int         cnt;
      bit         full, empty, af, ae, ovf, unf, chk;
      logic [7:0] rd;
   } exp_t;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       winc0 = 0, rinc0 = 0, winc1 = 0, rinc1 = 0;
   logic [7:0] wdata0 = '0, wdata1 = '0;
   logic [7:0] rdata0, rdata1;
   logic       wfull0, rempty0, af0, ae0, ovf0, unf0;
   logic       wfull1, rempty1, af1, ae1, ovf1, unf1;
   logic [4:0] count0;
   logic [2:0] count1;

   int checks = 0;
   int failures = 0;

   exp_t       exp_q[$];
   logic [7:0] q0[$];
   logic [7:0] q1[$];
   logic [7:0] rd0 = '0;

   always #5 clk = ~clk;

   syn_fifo_flags #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) dut0 (
      .clk(clk), .rstn(rstn), .winc(winc0), .wdata(wdata0), .rinc(rinc0),
      .rdata(rdata0), .wfull(wfull0), .rempty(rempty0), .almost_full(af0),
      .almost_empty(ae0), .count(count0), .overflow(ovf0), .underflow(unf0));

   syn_fifo_flags #(.WIDTH(8), .DEPTH(5), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1)) dut1 (
      .clk(clk), .rstn(rstn), .winc(winc1), .wdata(wdata1), .rinc(rinc1),
      .rdata(rdata1), .wfull(wfull1), .rempty(rempty1), .almost_full(af1),
      .almost_empty(ae1), .count(count1), .overflow(ovf1), .underflow(unf1));

   task automatic chk(input string name, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         failures++;
         $display("FAIL %s act=%0d exp=%0d at %0t", name, act, exp_v, $time);
      end
   endtask

   // Reference model: FIFO as a queue, rules taken from the block's contract.
   task automatic model(input int id, input bit w, input bit r, input logic [7:0] d);
      logic [7:0] q[$];
      int depth, af_l, ae_l, n;
      bit full, empty;
      exp_t e;
      if (id == 0) begin q = q0; depth = 16; af_l = 14; ae_l = 2; end
      else         begin q = q1; depth = 5;  af_l = 3;  ae_l = 1; end
      full  = (q.size() == depth);
      empty = (q.size() == 0);
      if (r && !empty) begin
         if (id == 0) rd0 = q[0];
         void'(q.pop_front());
      end
      if (w && !full) q.push_back(d);
      n = q.size();
      e.id = id; e.cnt = n;
      e.full = (n == depth); e.empty = (n == 0);
      e.af = (n >= af_l); e.ae = (n <= ae_l);
      e.ovf = w && full; e.unf = r && empty;
      if (id == 0) begin e.chk = 1; e.rd = rd0; q0 = q; end
      else begin e.chk = (n != 0); e.rd = (n != 0) ? q[0] : 8'h00; q1 = q; end
      exp_q.push_back(e);
   endtask

   task automatic cyc(input bit w0, input bit r0, input logic [7:0] d0,
                      input bit w1, input bit r1, input logic [7:0] d1);
      @(negedge clk);
      winc0 = w0; rinc0 = r0; wdata0 = d0;
      winc1 = w1; rinc1 = r1; wdata1 = d1;
      model(0, w0, r0, d0);
      model(1, w1, r1, d1);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_cnt0"}, count0, 0);  chk({tag, "_empty0"}, rempty0, 1);
      chk({tag, "_full0"}, wfull0, 0); chk({tag, "_ae0"}, ae0, 1);
      chk({tag, "_af0"}, af0, 0);      chk({tag, "_ovf0"}, ovf0, 0);
      chk({tag, "_unf0"}, unf0, 0);    chk({tag, "_rd0"}, rdata0, 0);
      chk({tag, "_cnt1"}, count1, 0);  chk({tag, "_empty1"}, rempty1, 1);
      chk({tag, "_full1"}, wfull1, 0); chk({tag, "_ae1"}, ae1, 1);
      chk({tag, "_af1"}, af1, 0);
   endtask

   // Monitor: after every edge, compare each DUT against its pending record.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (e.id == 0) begin
               chk("count0", count0, e.cnt);  chk("wfull0", wfull0, e.full);
               chk("rempty0", rempty0, e.empty); chk("af0", af0, e.af);
               chk("ae0", ae0, e.ae);         chk("ovf0", ovf0, e.ovf);
               chk("unf0", unf0, e.unf);      chk("rdata0", rdata0, e.rd);
            end else begin
               chk("count1", count1, e.cnt);  chk("wfull1", wfull1, e.full);
               chk("rempty1", rempty1, e.empty); chk("af1", af1, e.af);
               chk("ae1", ae1, e.ae);         chk("ovf1", ovf1, e.ovf);
               chk("unf1", unf1, e.unf);
               if (e.chk) chk("rdata1", rdata1, e.rd);
            end
         end
      end
   end

   initial begin
      // Reset values
      repeat (2) @(negedge clk);
      chk_reset("rst");
      rstn = 1'b1;

      // dut0: fill 0x01..0x10, overflow, drain, underflow
      for (int i = 1; i <= 16; i++) cyc(1, 0, 8'(i), 0, 0, 0);
      cyc(1, 0, 8'hEE, 0, 0, 0);
      for (int i = 0; i < 16; i++) cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);

      // Simultaneous access at empty, full and count=5
      cyc(1, 1, 8'h20, 0, 0, 0);
      for (int i = 0; i < 15; i++) cyc(1, 0, 8'(8'h21 + i), 0, 0, 0);
      cyc(1, 1, 8'h40, 0, 0, 0);
      for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0, 0, 0);
      cyc(1, 1, 8'h41, 0, 0, 0);
      for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, 0, 0);

      // dut1 FWFT: fill 0xA0..0xA4, 12 cycles of streaming, drain
      for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0, 8'(8'hA0 + i));
      for (int i = 0; i < 12; i++) cyc(0, 0, 0, 1, 1, 8'(8'hA5 + i));
      for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 1, 0);

      // FWFT single word fall-through, then pop
      cyc(0, 0, 0, 1, 0, 8'h3C);
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0, 0);

      // Randomized traffic on both FIFOs
      for (int i = 0; i < 400; i++)
         cyc($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 5, 8'($urandom),
             $urandom_range(0, 1), $urandom_range(0, 1), 8'($urandom));

      // Asynchronous reset with dut0 at count 7
      for (int i = 0; i < 20; i++) cyc(0, 1, 0, 0, 1, 0);
      for (int i = 0; i < 7; i++) cyc(1, 0, 8'(8'h60 + i), 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("pre_rst_cnt0", count0, 7);
      #2 rstn = 1'b0;
      #1 chk_reset("midrst");
      q0.delete(); q1.delete(); rd0 = '0;
      @(negedge clk);
      rstn = 1'b1;
      cyc(1, 0, 8'h55, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
